// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Hazard, freeze and flush sequencing around the ID stage of a
//               5-stage ARM pipeline. It detects RAW hazards against EXE/MEM,
//               freezes the pipe during SRAM accesses, flushes IF/ID on taken
//               branches, counts stall cycles and flags SRAM timeouts.
//
//               Optional macro FORWARDING_EN: when defined, an EXE forwarding
//               unit is assumed and only EXE load-use hazards stall.
//
// Ports       : clk, rst (sync, active-low)
//               RnAddress, RmAddress, Two_src, id_uses_rn  - ID operands
//               EXE_dest, EXE_WB_EN, EXE_MEM_R_EN          - EXE producer
//               MEM_dest, MEM_WB_EN                        - MEM producer
//               branch_taken, mem_req, mem_ready           - control events
//               hazard, freeze_if, freeze_pipe, flush      - pipeline controls
//               stall_count, mem_error                     - status
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           RnAddress,
  input  logic [3:0]           RmAddress,
  input  logic                 Two_src,
  input  logic                 id_uses_rn,
  input  logic [3:0]           EXE_dest,
  input  logic                 EXE_WB_EN,
  input  logic                 EXE_MEM_R_EN,
  input  logic [3:0]           MEM_dest,
  input  logic                 MEM_WB_EN,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 hazard,
  output logic                 freeze_if,
  output logic                 freeze_pipe,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic                 mem_error
);

  // Timeout counter wide enough to hold MEM_TIMEOUT; MEM_TIMEOUT must be >= 2.
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  // The counter value incremented in the current MEM_WAIT cycle reaches
  // MEM_TIMEOUT-1 when the registered value is MEM_TIMEOUT-2. Together with
  // the RUN entry cycle this gives exactly MEM_TIMEOUT frozen cycles.
  localparam logic [TW-1:0] c_timeoutLast = TW'(MEM_TIMEOUT - 2);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [TW-1:0]         r_timeout;
  logic [CNT_WIDTH-1:0]  r_stallCount;
  logic                  r_memError;

  logic w_srcMatchExe;
  logic w_srcMatchMem;
  logic w_rawExe;
  logic w_rawMem;
  logic w_rawStall;
  logic w_timeoutHit;

  assign w_srcMatchExe = (id_uses_rn && (RnAddress == EXE_dest)) ||
                         (Two_src    && (RmAddress == EXE_dest));
  assign w_srcMatchMem = (id_uses_rn && (RnAddress == MEM_dest)) ||
                         (Two_src    && (RmAddress == MEM_dest));
  assign w_rawExe      = EXE_WB_EN & w_srcMatchExe;
  assign w_rawMem      = MEM_WB_EN & w_srcMatchMem;

`ifdef FORWARDING_EN
  // Forwarding covers everything except a load whose data is not yet read.
  assign w_rawStall = EXE_MEM_R_EN & w_rawExe;
`else
  assign w_rawStall = w_rawExe | w_rawMem;
`endif

  assign w_timeoutHit = (r_state == MEM_WAIT) && !mem_ready &&
                        (r_timeout == c_timeoutLast);

  always_comb begin
    w_nextState = r_state;
    hazard      = 1'b0;
    freeze_pipe = 1'b0;
    flush       = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          // Memory access wins over a branch; EXE is frozen so the branch
          // is seen again once the access completes.
          w_nextState = MEM_WAIT;
          freeze_pipe = 1'b1;
          hazard      = w_rawStall;
        end else if (branch_taken) begin
          // Flush discards the ID instruction, so its hazard is moot.
          w_nextState = FLUSH;
          flush       = 1'b1;
        end else begin
          hazard      = w_rawStall;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          // Release in the ready cycle so the pipe advances on this edge.
          w_nextState = RUN;
        end else begin
          freeze_pipe = 1'b1;
          if (w_timeoutHit) begin
            w_nextState = RUN;
          end
        end
      end
      FLUSH: begin
        flush       = branch_taken;
        w_nextState = RUN;
      end
      default: begin
        w_nextState = RUN;
      end
    endcase
  end

  assign freeze_if   = hazard | freeze_pipe;
  assign stall_count = r_stallCount;
  assign mem_error   = r_memError;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= RUN;
      r_timeout    <= '0;
      r_stallCount <= '0;
      r_memError   <= 1'b0;
    end else begin
      r_state <= w_nextState;

      if ((r_state == MEM_WAIT) && (w_nextState == MEM_WAIT)) begin
        r_timeout <= r_timeout + 1'b1;
      end else begin
        r_timeout <= '0;
      end

      if ((hazard || freeze_pipe) && (r_stallCount != {CNT_WIDTH{1'b1}})) begin
        r_stallCount <= r_stallCount + 1'b1;
      end

      if (w_timeoutHit) begin
        r_memError <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed self-checking bench for pipeline_hazard_controller.
//               Built with MEM_TIMEOUT=8 and CNT_WIDTH=5 so the timeout and
//               counter saturation are reachable in a short run. Expected
//               hazard values follow FORWARDING_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_WIDTH   = 5;

`ifdef FORWARDING_EN
  localparam bit c_fwd = 1'b1;
`else
  localparam bit c_fwd = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           RnAddress, RmAddress, EXE_dest, MEM_dest;
  logic                 Two_src, id_uses_rn, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN;
  logic                 branch_taken, mem_req, mem_ready;
  logic                 hazard, freeze_if, freeze_pipe, flush, mem_error;
  logic [CNT_WIDTH-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  pipeline_hazard_controller #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RnAddress    (RnAddress),
    .RmAddress    (RmAddress),
    .Two_src      (Two_src),
    .id_uses_rn   (id_uses_rn),
    .EXE_dest     (EXE_dest),
    .EXE_WB_EN    (EXE_WB_EN),
    .EXE_MEM_R_EN (EXE_MEM_R_EN),
    .MEM_dest     (MEM_dest),
    .MEM_WB_EN    (MEM_WB_EN),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .hazard       (hazard),
    .freeze_if    (freeze_if),
    .freeze_pipe  (freeze_pipe),
    .flush        (flush),
    .stall_count  (stall_count),
    .mem_error    (mem_error)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clearInputs();
    RnAddress = 4'd0; RmAddress = 4'd0; Two_src = 1'b0; id_uses_rn = 1'b0;
    EXE_dest = 4'd0; EXE_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0;
    MEM_dest = 4'd0; MEM_WB_EN = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    clearInputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // ---- 1: reset mid MEM_WAIT ----
    mem_req = 1'b1;
    tick();                 // now in MEM_WAIT
    tick();
    rst = 1'b0;             // mem_req still high through reset
    tick();
    tick();
    rst = 1'b1;
    mem_req = 1'b0;
    settle();
    checkVal("rst_freeze_pipe", freeze_pipe, 0);
    checkVal("rst_freeze_if", freeze_if, 0);
    checkVal("rst_hazard", hazard, 0);
    checkVal("rst_flush", flush, 0);
    checkVal("rst_stall_count", stall_count, 0);
    checkVal("rst_mem_error", mem_error, 0);

    // ---- 2/3: RAW detection ----
    doReset();
    RnAddress = 4'd3; id_uses_rn = 1'b1; EXE_dest = 4'd3; EXE_WB_EN = 1'b1;
    settle();
    checkVal("raw_exe_hazard", hazard, c_fwd ? 0 : 1);
    checkVal("raw_exe_freeze_if", freeze_if, c_fwd ? 0 : 1);
    tick();
    EXE_WB_EN = 1'b0; EXE_dest = 4'd7; MEM_dest = 4'd3; MEM_WB_EN = 1'b1;
    settle();
    checkVal("raw_mem_hazard", hazard, c_fwd ? 0 : 1);
    tick();
    MEM_WB_EN = 1'b0; MEM_dest = 4'd9;
    settle();
    checkVal("nomatch_hazard", hazard, 0);
    checkVal("raw_stall_count", stall_count, c_fwd ? 0 : 2);
    EXE_dest = 4'd3; EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1;
    settle();
    checkVal("load_use_hazard", hazard, 1);
    tick();
    checkVal("load_use_stall_count", stall_count, c_fwd ? 1 : 3);
    EXE_MEM_R_EN = 1'b0; id_uses_rn = 1'b0; RnAddress = 4'd5;
    Two_src = 1'b1; RmAddress = 4'd5; EXE_dest = 4'd5;
    settle();
    checkVal("rm_match_hazard", hazard, c_fwd ? 0 : 1);
    Two_src = 1'b0;
    settle();
    checkVal("rn_unused_hazard", hazard, 0);
    Two_src = 1'b1; EXE_WB_EN = 1'b0;
    settle();
    checkVal("no_wb_hazard", hazard, 0);

    // ---- 4: SRAM wait ----
    doReset();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checkVal($sformatf("wait_freeze_pipe_%0d", i), freeze_pipe, 1);
      checkVal($sformatf("wait_freeze_if_%0d", i), freeze_if, 1);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    checkVal("ready_freeze_pipe", freeze_pipe, 0);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    settle();
    checkVal("after_ready_freeze_pipe", freeze_pipe, 0);
    checkVal("wait_stall_count", stall_count, 4);
    mem_req = 1'b1; mem_ready = 1'b1;
    settle();
    checkVal("zero_wait_freeze_pipe", freeze_pipe, 0);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    checkVal("zero_wait_stall_count", stall_count, 4);

    // ---- 5: timeout ----
    doReset();
    mem_req = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      settle();
      checkVal($sformatf("to_freeze_%0d", i), freeze_pipe, 1);
      checkVal($sformatf("to_err_pre_%0d", i), mem_error, 0);
      tick();
    end
    mem_req = 1'b0;
    settle();
    checkVal("timeout_mem_error", mem_error, 1);
    checkVal("timeout_back_to_run", freeze_pipe, 0);
    checkVal("timeout_stall_count", stall_count, MEM_TIMEOUT);
    tick();
    tick();
    tick();
    checkVal("mem_error_sticky", mem_error, 1);
    doReset();
    settle();
    checkVal("mem_error_cleared", mem_error, 0);

    // ---- 6: branch flush ----
    doReset();
    RnAddress = 4'd3; id_uses_rn = 1'b1; EXE_dest = 4'd3;
    EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1;
    branch_taken = 1'b1;
    settle();
    checkVal("br_flush", flush, 1);
    checkVal("br_hazard", hazard, 0);
    checkVal("br_freeze_if", freeze_if, 0);
    tick();
    settle();
    checkVal("br2_flush", flush, 1);
    checkVal("br2_hazard", hazard, 0);
    tick();
    branch_taken = 1'b0;
    settle();
    checkVal("br_done_flush", flush, 0);
    checkVal("br_done_run_hazard", hazard, 1);
    checkVal("br_stall_count", stall_count, 0);
    EXE_WB_EN = 1'b0;
    mem_req = 1'b1; branch_taken = 1'b1;
    settle();
    checkVal("memreq_prio_freeze", freeze_pipe, 1);
    checkVal("memreq_prio_flush", flush, 0);

    // ---- stall_count saturation ----
    doReset();
    RnAddress = 4'd2; id_uses_rn = 1'b1; EXE_dest = 4'd2;
    EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    checkVal("sat_stall_count", stall_count, 31);
    tick();
    checkVal("sat_hold_stall_count", stall_count, 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage ARM pipeline around the ID stage.
- Detects RAW hazards between the ID source operands and the EXE/MEM destinations, and drives the ID `hazard` input and the IF PC-hold.
- Freezes the whole pipeline while the SRAM data-memory access is outstanding.
- Issues a one-cycle flush of IF/ID on a taken branch.
- Keeps a stall performance counter and a sticky memory-timeout flag.

Parameters:
- MEM_TIMEOUT, 64: max cycles in MEM_WAIT before mem_error is set.
- CNT_WIDTH, 16: width of stall_count.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
- RnAddress  in  4  ID first source register
- RmAddress  in  4  ID second source register
- Two_src  in  1  ID instruction reads RmAddress
- id_uses_rn  in  1  ID instruction reads RnAddress (0 for B, MOV, MVN)
- EXE_dest  in  4  destination register of the instruction in EXE
- EXE_WB_EN  in  1  EXE instruction writes back
- EXE_MEM_R_EN  in  1  EXE instruction is a load
- MEM_dest  in  4  destination register of the instruction in MEM
- MEM_WB_EN  in  1  MEM instruction writes back
- branch_taken  in  1  EXE resolved a taken branch (B after condition)
- mem_req  in  1  MEM stage starts an SRAM access (MEM_R_EN | MEM_W_EN)
- mem_ready  in  1  SRAM access complete
- hazard  out  1  to ID: bubble the controls and hold IF/ID
- freeze_if  out  1  hold PC and the IF/ID register
- freeze_pipe  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers
- flush  out  1  clear the IF/ID and ID/EXE registers
- stall_count  out  CNT_WIDTH  cycles with hazard or freeze_pipe asserted
- mem_error  out  1  sticky SRAM timeout

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=RUN; timeout counter=0.
  - stall_count=0; mem_error=0.
  - All registered outputs=0.
  - Reset overrides everything, including mid-MEM_WAIT.
- Match functions:
  - src_match(d) = (id_uses_rn & RnAddress==d) | (Two_src & RmAddress==d).
  - raw_exe = EXE_WB_EN & src_match(EXE_dest).
  - raw_mem = MEM_WB_EN & src_match(MEM_dest).
- hazard (combinational, state RUN only) = raw_exe | raw_mem, subject to the Optional Feature.
- freeze_if = hazard | freeze_pipe.
- FSM states: RUN, MEM_WAIT, FLUSH.
- RUN:
  - If mem_req & ~mem_ready: go to MEM_WAIT; freeze_pipe=1 combinationally in this same cycle.
  - Else if branch_taken: go to FLUSH; flush=1 combinationally in this same cycle.
  - mem_req takes priority over branch_taken. A branch and a memory op cannot coexist in EXE and MEM with branch_taken lost: in MEM_WAIT the EXE stage is frozen, so branch_taken is re-sampled on return to RUN.
  - mem_req & mem_ready in the same cycle: zero-wait access, stay in RUN, no freeze.
- MEM_WAIT:
  - freeze_pipe=1, freeze_if=1, hazard=0, flush=0.
  - Timeout counter increments each cycle.
  - mem_ready=1: go to RUN next cycle. freeze_pipe is deasserted in that mem_ready cycle, so the pipeline advances on that edge.
  - Counter reaches MEM_TIMEOUT-1 without mem_ready: set mem_error=1 (sticky until reset), go to RUN, continue.
  - Counter clears on leaving MEM_WAIT.
- FLUSH:
  - A single cycle; flush was already asserted in the entry cycle.
  - In FLUSH, flush=1 again only if branch_taken=1 (back-to-back branch); otherwise 0.
  - hazard=0 in FLUSH, since the ID instruction is discarded.
  - Next state: RUN.
- Simultaneous hazard and branch_taken in RUN: flush=1 and hazard=0; flush wins.
- stall_count:
  - Increments on every clk where (hazard | freeze_pipe)=1.
  - Saturates at all-ones; no wrap.
- Latency: all hazard, freeze and flush decisions are combinational from the current-cycle inputs plus registered state. Only the state, timeout counter, stall_count and mem_error are registered.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined (EXE-stage forwarding unit present):
  - hazard = EXE_EXE_load_use only, i.e. EXE_MEM_R_EN & EXE_WB_EN & src_match(EXE_dest).
  - raw_mem and non-load raw_exe do not stall.
- Undefined: hazard = raw_exe | raw_mem, as above.

Test Plan:
1. rst=0 for 2 cycles mid-MEM_WAIT, then rst=1 → state RUN, all outputs 0, stall_count=0, mem_error=0.
2. No FORWARDING_EN; ID Rn=3, id_uses_rn=1; EXE_dest=3, EXE_WB_EN=1 → hazard=1 and freeze_if=1 that cycle. Move the producer to MEM (MEM_dest=3) → hazard=1. Then no match → hazard=0; stall_count=2.
3. FORWARDING_EN defined; same as 2 with EXE_MEM_R_EN=0 → hazard=0. With EXE_MEM_R_EN=1 → hazard=1. With MEM_dest match only → hazard=0.
4. mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 → freeze_pipe=1 for 4 cycles and 0 in the ready cycle; state back to RUN; stall_count=4.
5. MEM_TIMEOUT=8; mem_req held with mem_ready=0 → after 8 freeze cycles mem_error=1, FSM returns to RUN. mem_error stays 1 until reset.
6. branch_taken=1 with a simultaneous RAW match → flush=1 and hazard=0 that cycle. branch_taken again next cycle (FLUSH) → flush=1. Then branch_taken=0 → flush=0, RUN.
